// File: rtl/dbg_pkg.sv
// Shared types for the debug memory responder: FSM state encoding and error codes.
package dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } dbg_state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ADDR    = 2'd1,
        ERR_TIMEOUT = 2'd2
    } dbg_err_e;

    localparam int CNT_W = 8;

endpackage

// File: rtl/dbg_addr_chk.sv
// Combinational legality check of a debug byte address against the served RAM window.
module dbg_addr_chk #(
    parameter int          AW       = 32,
    parameter logic [AW-1:0] MEM_BASE = '0,
    parameter int          MEM_NUM  = 4096,
    parameter int          IW       = 12
) (
    input  logic [AW-1:0] addr,
    output logic          legal,
    output logic [IW-1:0] index
);

    logic [AW-1:0] off;

    // Subtraction wraps for addresses below the base, so those land far out of range.
    assign off   = addr - MEM_BASE;
    assign legal = (addr[1:0] == 2'b00) && ((off >> 2) < AW'(MEM_NUM));
    assign index = IW'(off >> 2);

endmodule

// File: rtl/dbg_mem_resp.sv
// Debug access port sharing a single-port RAM with the core data port.
// Optional wait-state timeout enabled by defining DBG_MEM_TIMEOUT_EN.
module dbg_mem_resp
    import dbg_pkg::*;
#(
    parameter int          DW       = 32,
    parameter int          AW       = 32,
    parameter logic [31:0] MEM_BASE = 32'h0000_0000,
    parameter int          MEM_NUM  = 4096,
    parameter int          TIMEOUT  = 255,
    localparam int         IW       = (MEM_NUM > 1) ? $clog2(MEM_NUM) : 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_err,
    input  logic          core_halted,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [IW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    dbg_state
);

    localparam logic [AW-1:0] BASE_A = AW'(MEM_BASE);

    dbg_state_e    state_q, state_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    dbg_err_e      err_q, err_d;

    logic          addr_legal;
    logic [IW-1:0] dbg_idx;
    logic [IW-1:0] core_idx;

`ifdef DBG_MEM_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    assign cnt_inc = cnt_q + CNT_W'(1);
`endif

    dbg_addr_chk #(
        .AW       (AW),
        .MEM_BASE (BASE_A),
        .MEM_NUM  (MEM_NUM),
        .IW       (IW)
    ) u_addr_chk (
        .addr  (addr_q),
        .legal (addr_legal),
        .index (dbg_idx)
    );

    assign core_idx  = IW'((core_addr - BASE_A) >> 2);
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
`ifdef DBG_MEM_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (dbg_req) begin
                    we_d    = dbg_we;
                    addr_d  = dbg_addr;
                    wdata_d = dbg_wdata;
                    err_d   = ERR_NONE;
`ifdef DBG_MEM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
`ifdef DBG_MEM_TIMEOUT_EN
                cnt_d = cnt_inc;
`endif
                if (!addr_legal) begin
                    err_d   = ERR_ADDR;
                    state_d = ST_RESP;
                end else if (core_halted || !core_req) begin
                    state_d = ST_ACCESS;
                end
`ifdef DBG_MEM_TIMEOUT_EN
                else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_RESP;
                end
`endif
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // The RAM belongs to the core except for the single ACCESS cycle.
    always_comb begin
        core_gnt  = core_req;
        mem_cs    = core_req;
        mem_we    = core_we;
        mem_addr  = core_idx;
        mem_wdata = core_wdata;
        dbg_ack   = 1'b0;
        dbg_err   = 1'b0;
        dbg_rdata = '0;
        case (state_q)
            ST_ACCESS: begin
                core_gnt  = 1'b0;
                mem_cs    = 1'b1;
                mem_we    = we_q;
                mem_addr  = dbg_idx;
                mem_wdata = wdata_q;
            end
            ST_RESP: begin
                dbg_ack = 1'b1;
                dbg_err = (err_q != ERR_NONE);
                if (!we_q && (err_q == ERR_NONE)) begin
                    dbg_rdata = mem_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= ERR_NONE;
`ifdef DBG_MEM_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
`ifdef DBG_MEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: doc/dbg_mem_resp.md
DBG_MEM_RESP -- requirements
Module: dbg_mem_resp

Interface
REQ-001 The block SHALL have parameters: DW, default 32, data width; AW, default 32, address width; MEM_BASE, default 32'h0000_0000, byte base address of the served RAM; MEM_NUM, default 4096, RAM depth in words; TIMEOUT, default 255, maximum wait cycles for a debug request.
REQ-002 The block SHALL have these ports:
- clk  in  1  system clock, the single clock
- rstn  in  1  asynchronous active-low reset
- dbg_req  in  1  debug access request, held until acknowledged
- dbg_we  in  1  debug write (1) or read (0)
- dbg_addr  in  AW  debug byte address
- dbg_wdata  in  DW  debug write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  DW  debug read data, valid with dbg_ack
- dbg_err  out  1  error flag, valid with dbg_ack
- core_halted  in  1  core halted by debug
- core_req  in  1  core data-port request
- core_we  in  1  core write
- core_addr  in  AW  core byte address
- core_wdata  in  DW  core write data
- core_gnt  out  1  core request granted this cycle
- mem_cs  out  1  RAM select
- mem_we  out  1  RAM write enable
- mem_addr  out  log2(MEM_NUM)  RAM word index
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, one cycle after mem_cs with mem_we=0

Function
REQ-003 The block SHALL implement states IDLE, WAIT, ACCESS and RESP.
REQ-004 In IDLE with dbg_req=1, the block SHALL capture dbg_we, dbg_addr and dbg_wdata into internal registers and move to WAIT.
REQ-005 The block SHALL treat a captured address as illegal if it is not word-aligned (addr[1:0]!=0) or if (addr-MEM_BASE)>>2 >= MEM_NUM.
REQ-006 For an illegal address, the block SHALL go WAIT->RESP with dbg_err=1, without asserting mem_cs for the debug request.
REQ-007 In WAIT, the block SHALL move to ACCESS in the cycle where core_halted=1 or core_req=0.
REQ-008 In ACCESS, the block SHALL drive mem_cs=1, mem_we=captured we, mem_addr=(addr-MEM_BASE)>>2 and mem_wdata=captured data, with core_gnt=0.
REQ-009 ACCESS SHALL always be followed by RESP.
REQ-010 In RESP, the block SHALL pulse dbg_ack for exactly one cycle and then return to IDLE.
REQ-011 In RESP, dbg_rdata SHALL equal mem_rdata for reads and 0 for writes.
REQ-012 In every state other than ACCESS, the block SHALL pass the core request through combinationally: core_gnt=core_req, mem_cs=core_req, and mem_we/mem_addr/mem_wdata taken from the core inputs.
REQ-013 When core_halted=1, the core SHALL still be granted outside ACCESS.
REQ-014 Uncontended latency SHALL be 3 cycles: dbg_req sampled in cycle N, WAIT in N+1, ACCESS in N+2, dbg_ack in N+3.
REQ-015 If dbg_req falls before acknowledgement, the block SHALL complete the captured access anyway, because the request is already latched.
REQ-016 After RESP, IDLE SHALL re-sample dbg_req, so a still-asserted dbg_req starts a new access.

Reset
REQ-017 While rstn=0, the block SHALL hold state IDLE; dbg_ack=0, dbg_err=0, dbg_rdata=0 and the captured registers=0.
REQ-018 Reset asserted mid-access SHALL abort the access with no acknowledgement.
REQ-019 mem_cs and core_gnt SHALL follow core_req during reset.

Configuration
REQ-020 With DBG_MEM_TIMEOUT_EN defined, an 8-bit wait counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-021 With DBG_MEM_TIMEOUT_EN defined, reaching TIMEOUT in WAIT SHALL force RESP with dbg_err=1 and no RAM access.
REQ-022 Without DBG_MEM_TIMEOUT_EN, the counter SHALL be absent and WAIT SHALL be unbounded.

Structure
REQ-023 The state encoding (2-bit) and the error code constants SHALL live in the shared package dbg_pkg.
REQ-024 The address legality check SHALL be one sub-module, dbg_addr_chk (combinational: addr in, legal and index out).

Verification
REQ-025 The bench SHALL cover: core_req=0, debug write 0x0000_0010 data 0xDEADBEEF -> mem_we=1, mem_addr=4 in ACCESS, dbg_ack 3 cycles after dbg_req, dbg_err=0.
REQ-026 The bench SHALL cover: read back 0x0000_0010 -> dbg_rdata=0xDEADBEEF with dbg_ack.
REQ-027 The bench SHALL cover: dbg_addr=0x0000_0012 or 0x0000_4000 (MEM_NUM=4096) -> dbg_ack with dbg_err=1 and no debug mem_cs.
REQ-028 The bench SHALL cover: core_req held 1 with core_halted=0 for 10 cycles -> debug stays in WAIT; core_gnt=1 throughout; dbg_ack 2 cycles after core_req falls.
REQ-029 The bench SHALL cover: with DBG_MEM_TIMEOUT_EN, TIMEOUT=8, core_req stuck 1 -> dbg_ack with dbg_err=1 after 8 WAIT cycles.
REQ-030 The bench SHALL cover: rstn pulled low in ACCESS -> no dbg_ack; the next request completes normally.
